// File: rtl/nibble_serial_adder.sv
// Purpose: WIDTH-bit adder built from one 4-bit ripple slice reused LSB nibble first.
// Latency: N = WIDTH/4 cycles from accept edge to out_valid.
// Backpressure: result held in HOLD until out_ready. in_ready is low while busy.
//
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with a, b, cin;
//        out_valid/out_ready with sum, cout, ovf.
// Optional feature: define NSA_OVERFLOW_EN to compute signed overflow on ovf.
// Without it, ovf is tied to 0.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            c_q, c_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic            cout_q, cout_d;
  logic [3:0]      nib_a, nib_b;
  logic [4:0]      slice_s;
  logic            last_nib;

  // Select the current nibble pair with an explicit mux; the slice sees
  // one nibble of each operand plus the carry from the previous nibble.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IW'(k)) begin
        nib_a = op_a_q[4*k +: 4];
        nib_b = op_b_q[4*k +: 4];
      end
    end
  end

  assign slice_s  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, c_q};
  assign last_nib = (idx_q == IW'(N - 1));

`ifdef NSA_OVERFLOW_EN
  logic ovf_q, ovf_d;
  // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
  logic ovf_last;
  assign ovf_last = op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1] ^ slice_s[3] ^ slice_s[4];
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef NSA_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = a;
          op_b_d  = b;
          c_d     = cin;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef NSA_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        for (int k = 0; k < N; k++) begin
          if (idx_q == IW'(k)) begin
            sum_d[4*k +: 4] = slice_s[3:0];
          end
        end
        c_d = slice_s[4];
        if (last_nib) begin
          cout_d  = slice_s[4];
`ifdef NSA_OVERFLOW_EN
          ovf_d   = ovf_last;
`endif
          idx_d   = '0;
          state_d = HOLD;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      c_q     <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef NSA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef NSA_OVERFLOW_EN
  assign ovf       = ovf_q;
`else
  assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int acc_q[$];
  logic [WIDTH+1:0] res_q[$];

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Records accept cycles and completed results for the back-to-back check.
  always @(posedge clk) begin
    if (in_valid && in_ready) acc_q.push_back(cyc_cnt);
    if (out_valid && out_ready) res_q.push_back({ovf, cout, sum});
    cyc_cnt <= cyc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer addition; overflow from signed range check.
  function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] ra,
                                               input logic [WIDTH-1:0] rb,
                                               input logic rc);
    logic [WIDTH:0] full;
    logic           v;
    longint         s;
    full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
    s = longint'($signed(ra)) + longint'($signed(rb)) + longint'(rc);
    v = 1'b0;
`ifdef NSA_OVERFLOW_EN
    v = (s > ((longint'(1) <<< (WIDTH-1)) - 1)) || (s < -(longint'(1) <<< (WIDTH-1)));
`endif
    return {v, full};
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tc, input int hold);
    logic [WIDTH+1:0] exp;
    int cyc;
    exp = ref_add(ta, tb_v, tc);
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("in_ready_idle", in_ready, 1);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    // Operand changes after the accept edge must not matter.
    in_valid = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    chk("busy_in_ready", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("latency", cyc, N);
    chk("sum", sum, exp[WIDTH-1:0]);
    chk("cout", cout, exp[WIDTH]);
    chk("ovf", ovf, exp[WIDTH+1]);
    chk("hold_in_ready", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", sum, exp[WIDTH-1:0]);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_sum_kept", {cout, sum}, exp[WIDTH:0]);
  endtask

  initial begin
    logic [WIDTH-1:0] pa [3];
    logic [WIDTH-1:0] pb [3];
    logic             pc [3];
    logic [WIDTH+1:0] exp;
    int cyc;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    // Directed cases
    run_op(16'h1234, 16'h0FFF, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 0);
    run_op(16'h00F0, 16'h0010, 1'b1, 5);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1);
    run_op(16'h8000, 16'h8000, 1'b0, 0);

    // Reset in the middle of an operation
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;          // E0
    in_valid = 1'b0;
    @(posedge clk); #1;          // E1
    rst_n = 1'b0;
    @(posedge clk); #1;          // E2 with reset
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    rst_n = 1'b1;
    run_op(16'h0001, 16'h0001, 1'b0, 0);

    // Random operands and random backpressure
    for (int i = 0; i < 20; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Back-to-back with in_valid held high
    pa[0] = 16'h1111; pb[0] = 16'h2222; pc[0] = 1'b0;
    pa[1] = 16'hFFF0; pb[1] = 16'h0011; pc[1] = 1'b1;
    pa[2] = WIDTH'($urandom); pb[2] = WIDTH'($urandom); pc[2] = 1'($urandom);
    acc_q.delete();
    res_q.delete();
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = pa[0]; b = pb[0]; cin = pc[0];
    for (int i = 0; i < 3; i++) begin
      cyc = 0;
      while (acc_q.size() < i + 1 && cyc < 50) begin
        @(posedge clk); #1; cyc++;
      end
      chk("b2b_accept_seen", acc_q.size() >= i + 1, 1);
      if (i < 2) begin
        a = pa[i+1]; b = pb[i+1]; cin = pc[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    cyc = 0;
    while (res_q.size() < 3 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("b2b_results", res_q.size(), 3);
    out_ready = 1'b0;
    if (acc_q.size() == 3) begin
      chk("b2b_gap0", acc_q[1] - acc_q[0], N + 2);
      chk("b2b_gap1", acc_q[2] - acc_q[1], N + 2);
    end
    for (int i = 0; i < 3; i++) begin
      if (res_q.size() > i) begin
        exp = ref_add(pa[i], pb[i], pc[i]);
        chk("b2b_result", res_q[i], exp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide-operand adder that reuses one 4-bit ripple-carry slice over successive clock cycles. It accepts a WIDTH-bit operand pair plus carry-in through a valid/ready handshake and presents one nibble per cycle to the slice, LSB first. It registers the inter-nibble carry and assembles the WIDTH-bit sum and final carry-out. It sits between the operand source and result consumer, wrapping the 4-bit adder datapath.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of 4 and at least 4; N = WIDTH/4 slice cycles
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  operand A, sampled on accept edge only
- b  input  WIDTH  operand B, sampled on accept edge only
- cin  input  1  carry-in, sampled on accept edge only
- out_valid  output  1  result valid; high only in HOLD
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  registered sum
- cout  output  1  registered carry-out of MSB nibble
- ovf  output  1  signed overflow; see Configuration

## Operation
- States: IDLE, ADD, HOLD; nibble index idx, width ceil(log2(N)) with minimum 1; carry register c_r.
- IDLE behaviour:
  - in_ready=1.
  - On in_valid=1, latch a, b, cin into op_a, op_b, c_r.
  - Clear sum, cout and ovf to 0, set idx=0, go to ADD.
- ADD behaviour, each cycle:
  - Nibble k=idx: s_k = op_a[4k+3:4k] + op_b[4k+3:4k] + c_r.
  - sum[4k+3:4k] <= s_k[3:0]; c_r <= s_k[4]; idx <= idx+1.
  - When idx==N-1, cout <= s_k[4], go to HOLD.
- HOLD behaviour:
  - out_valid=1; sum and cout stable.
  - On out_ready=1, go to IDLE.
- in_valid is ignored outside IDLE. Operand changes after the accept edge have no effect.
- Arithmetic: {cout,sum} = a + b + cin, exact, modulo 2^(WIDTH+1).
- After the result handshake, sum, cout and ovf keep their values until the next accept edge.
- Reset (rst_n=0 at any edge, including mid-ADD or in HOLD):
  - State goes to IDLE; idx=0, c_r=0.
  - sum=0, cout=0, ovf=0, out_valid=0.
  - in_ready=1 from the first edge with rst_n=1 sampled… i.e. immediately after reset edge.
  - The in-flight operation is discarded, with no partial result.

## Timing
- Accept edge E0 is the edge where in_valid & in_ready. Edges E1..EN each process one nibble.
- out_valid rises after edge EN: N cycles of latency (4 for WIDTH=16).
- Result handshake completes at the edge where out_valid & out_ready. in_ready is high from the following cycle.
- No accept can occur in the same cycle as the result handshake.
- Minimum issue interval is N+2 cycles.
- in_ready and out_valid are decoded from the state register only, with no combinational path from inputs.
- WIDTH=4 case: a single ADD cycle, then HOLD.

## Configuration
- NSA_OVERFLOW_EN defined:
  - During the last ADD cycle, ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (two's-complement overflow).
  - ovf is valid with out_valid.
- NSA_OVERFLOW_EN undefined:
  - ovf port still present, tied to 0.
  - No overflow logic synthesized.

## Test plan
- Basic add: WIDTH=16, a=16'h1234, b=16'h0FFF, cin=0, out_ready=1 → out_valid exactly 4 cycles after accept; sum=16'h2233, cout=0.
- Full carry ripple across nibbles: a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1. Also a=16'hFFFF, b=16'h0000, cin=1 → sum=16'h0000, cout=1.
- Backpressure: a=16'h00F0, b=16'h0010, cin=1 with out_ready=0 for 5 cycles:
  - out_valid stays 1 and sum=16'h0101 stays stable throughout.
  - in_valid=1 with different operands is not accepted (in_ready=0).
  - After out_ready=1, in_ready=1 the next cycle.
- Reset mid-op: accept a=16'hAAAA, b=16'h5555, drive rst_n=0 at E2 → next cycle state IDLE, sum=0, cout=0, out_valid=0, in_ready=1. A new a=16'h0001, b=16'h0001 then yields 16'h0002.
- Overflow (NSA_OVERFLOW_EN defined):
  - a=16'h7FFF, b=16'h0001 → sum=16'h8000, cout=0, ovf=1.
  - a=16'hFFFF, b=16'h0001 → ovf=0.
  - With macro undefined, ovf=0 for both.
- Back-to-back: in_valid held high with three operand pairs and out_ready=1 → accepts spaced exactly 6 cycles apart, all three sums correct.
